// File: rtl/sdram_chip_model.sv
// Behavioural SDR SDRAM device: command decode, per-bank open rows, byte-masked
// storage, burst engine and a CAS-latency read pipeline driving the shared dq bus.
module sdram_chip_model #(
   parameter int BANK_W = 2,
   parameter int ROW_W  = 13,
   parameter int COL_W  = 9,
   parameter int DATA_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  sdram_cke,
   input  logic                  sdram_cs,
   input  logic                  sdram_ras,
   input  logic                  sdram_cas,
   input  logic                  sdram_we,
   input  logic [13:0]           sdram_a,
   input  logic [BANK_W-1:0]     sdram_ba,
   input  logic [DATA_W/8-1:0]   sdram_dqm,
   inout  wire  [DATA_W-1:0]     sdram_dq,
   output logic                  protocol_err
);

   localparam int LANES  = DATA_W / 8;
   localparam int NBANK  = 1 << BANK_W;
   localparam int ADDR_W = BANK_W + ROW_W + COL_W;
   localparam int DEPTH  = 1 << ADDR_W;

   // Command encodings on {cs, ras, cas, we}
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;
   localparam logic [3:0] CMD_BST = 4'b0110;

   logic [3:0]        cmd;
   logic              is_act, is_read, is_write, is_pre, is_ref, is_lmr, is_bst;
   logic              cmd_bank_open, burst_stop, burst_go, new_burst;
   logic [COL_W-1:0]  cmd_col, mask_ext, beat_col;
   logic [2:0]        bl_mask;
   logic              rd_en, wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [LANES-1:0]  lane_we;
   logic              unused_bits;

   // Device state
   logic [NBANK-1:0]  bank_active_reg;
   logic [ROW_W-1:0]  open_row_reg [NBANK];
   logic [1:0]        bl_code_reg;
   logic              cl3_reg;
   logic [2:0]        burst_left_reg, burst_idx_reg, burst_mask_reg;
   logic              burst_write_reg;
   logic [BANK_W-1:0] burst_bank_reg;
   logic [COL_W-1:0]  burst_col_reg;
   logic              rd_valid_reg;
   logic [1:0]        pipe_v_reg;
   logic [DATA_W-1:0] pipe_d_reg [2];
   logic              dq_oe_reg;
   logic [DATA_W-1:0] dq_out_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic [DATA_W-1:0] mem [DEPTH];

   assign cmd      = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
   assign is_act   = (cmd == CMD_ACT);
   assign is_read  = (cmd == CMD_RD);
   assign is_write = (cmd == CMD_WR);
   assign is_pre   = (cmd == CMD_PRE);
   assign is_ref   = (cmd == CMD_REF);
   assign is_lmr   = (cmd == CMD_LMR);
   assign is_bst   = (cmd == CMD_BST);

   assign cmd_bank_open = bank_active_reg[sdram_ba];
   assign cmd_col       = sdram_a[COL_W-1:0];
   assign unused_bits   = &{1'b0, sdram_a};

   // Any column command, terminate, or closing the bursting bank ends the burst
   assign burst_stop = is_read || is_write || is_bst ||
                       (is_pre && (sdram_a[10] || (sdram_ba == burst_bank_reg)));
   assign burst_go   = (burst_left_reg != 3'd0) && !burst_stop;
   assign new_burst  = (is_read || is_write) && cmd_bank_open;

   // Burst column wraps inside the BL-aligned block
   assign mask_ext = COL_W'(burst_mask_reg);
   assign beat_col = (burst_col_reg & ~mask_ext) |
                     ((burst_col_reg + COL_W'(burst_idx_reg)) & mask_ext);

   // Burst length code to column wrap mask
   always_comb begin
      case (bl_code_reg)
         2'd0:    bl_mask = 3'd0;
         2'd1:    bl_mask = 3'd1;
         2'd2:    bl_mask = 3'd3;
         default: bl_mask = 3'd7;
      endcase
   end

   // Select the storage access for this edge: a new column command or a burst beat
   always_comb begin
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      mem_addr = '0;
      if (new_burst) begin
         mem_addr = {sdram_ba, open_row_reg[sdram_ba], cmd_col};
         rd_en    = is_read;
         wr_en    = is_write;
      end else if (burst_go) begin
         mem_addr = {burst_bank_reg, open_row_reg[burst_bank_reg], beat_col};
         rd_en    = !burst_write_reg;
         wr_en    = burst_write_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
         assign lane_we[gi] = wr_en && !sdram_dqm[gi];
      end
   endgenerate

   // Storage: byte-lane writes and registered read; contents survive reset
   always_ff @(posedge clock) begin
      if (sdram_cke) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) mem[mem_addr][i*8 +: 8] <= sdram_dq[i*8 +: 8];
         end
         if (rd_en) rd_data_reg <= mem[mem_addr];
      end
   end

   // Command decode, bank/mode state, burst engine and CAS-latency read pipeline
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         protocol_err    <= 1'b0;
         bank_active_reg <= '0;
         for (int b = 0; b < NBANK; b++) open_row_reg[b] <= '0;
         bl_code_reg     <= 2'd0;
         cl3_reg         <= 1'b0;
         burst_left_reg  <= 3'd0;
         burst_idx_reg   <= 3'd0;
         burst_mask_reg  <= 3'd0;
         burst_write_reg <= 1'b0;
         burst_bank_reg  <= '0;
         burst_col_reg   <= '0;
         rd_valid_reg    <= 1'b0;
         pipe_v_reg      <= 2'b00;
         pipe_d_reg[0]   <= '0;
         pipe_d_reg[1]   <= '0;
         dq_oe_reg       <= 1'b0;
         dq_out_reg      <= '0;
      end else if (sdram_cke) begin
         dq_oe_reg     <= pipe_v_reg[0];
         dq_out_reg    <= pipe_d_reg[0];
         pipe_v_reg[0] <= pipe_v_reg[1];
         pipe_d_reg[0] <= pipe_d_reg[1];
         pipe_v_reg[1] <= 1'b0;
         if (rd_valid_reg) begin
            if (cl3_reg) begin
               pipe_v_reg[1] <= 1'b1;
               pipe_d_reg[1] <= rd_data_reg;
            end else begin
               pipe_v_reg[0] <= 1'b1;
               pipe_d_reg[0] <= rd_data_reg;
            end
         end
         rd_valid_reg <= rd_en;

         if (is_lmr) begin
            if (sdram_a[2:0] <= 3'd3) bl_code_reg <= sdram_a[1:0];
            else                      protocol_err <= 1'b1;
            if (sdram_a[6:4] == 3'd2)      cl3_reg <= 1'b0;
            else if (sdram_a[6:4] == 3'd3) cl3_reg <= 1'b1;
            else                           protocol_err <= 1'b1;
         end
         if (is_act) begin
            if (cmd_bank_open) protocol_err <= 1'b1;
            bank_active_reg[sdram_ba] <= 1'b1;
            open_row_reg[sdram_ba]    <= sdram_a[ROW_W-1:0];
         end
         if (is_pre) begin
            if (sdram_a[10]) bank_active_reg <= '0;
            else             bank_active_reg[sdram_ba] <= 1'b0;
         end
         if (is_ref && (bank_active_reg != '0)) protocol_err <= 1'b1;
         if ((is_read || is_write) && !cmd_bank_open) protocol_err <= 1'b1;
         // Controller driving dq while this device is still driving a read beat
         if (is_write && dq_oe_reg) protocol_err <= 1'b1;

         if (new_burst) begin
            burst_left_reg  <= bl_mask;
            burst_idx_reg   <= 3'd1;
            burst_mask_reg  <= bl_mask;
            burst_write_reg <= is_write;
            burst_bank_reg  <= sdram_ba;
            burst_col_reg   <= cmd_col;
         end else if (burst_go) begin
            burst_left_reg <= burst_left_reg - 3'd1;
            burst_idx_reg  <= burst_idx_reg + 3'd1;
         end else begin
            burst_left_reg <= 3'd0;
         end
      end
   end

   assign sdram_dq = dq_oe_reg ? dq_out_reg : {DATA_W{1'bz}};

endmodule

// File: doc/sdram_chip_model.md
# sdram_chip_model

Cycle-accurate behavioural model of a single-rank, 32-bit-wide SDR SDRAM device. It sits directly downstream of the APB SDRAM controller in the SoC memory path and consumes its `sdram_*` pins: it decodes commands, tracks per-bank open rows, holds the storage array, and drives read data back on the shared bus after the programmed CAS latency. It exists so that controller and full-SoC simulations run against a real protocol-checking device rather than a flat memory.

## Interface
- `BANK_W`, default 2: bank address bits (4 banks).
- `ROW_W`, default 13: row address bits on `sdram_a`.
- `COL_W`, default 9: column address bits, `sdram_a[COL_W-1:0]`.
- `DATA_W`, default 32: dq width, byte-lane count = DATA_W/8.
- `clock`  in  1: device clock, driven from controller `sdram_clk`; all sampling on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `sdram_cke`  in  1: clock enable; low = edge ignored entirely (no state change, pipeline frozen).
- `sdram_cs`, `sdram_ras`, `sdram_cas`, `sdram_we`  in  1 each: active-low command pins.
- `sdram_a`  in  14: row / column / mode address; `a[10]` = all-banks on PRECHARGE.
- `sdram_ba`  in  BANK_W: bank select.
- `sdram_dqm`  in  DATA_W/8: write byte mask, 1 = lane masked.
- `sdram_dq`  inout  DATA_W: bidirectional data; model drives only during read beats, else high-Z.
- `protocol_err`  out  1: sticky protocol-violation flag for benches.

## Operation
- Command = {cs,ras,cas,we}: 1xxx DESELECT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO REFRESH, 0000 LOAD MODE, 0110 BURST TERMINATE.
- Mode register: `a[2:0]` burst length code (0→1, 1→2, 2→4, 3→8; other codes set `protocol_err`, BL unchanged); `a[6:4]` CAS latency, only 2 or 3 accepted (others set `protocol_err`). Reset value: BL=1, CL=2.
- Per bank: `active` bit + open row register. ACTIVE on already-active bank sets `protocol_err`, row overwritten. PRECHARGE clears bank `ba`, or all banks when `a[10]`=1. AUTO REFRESH with any bank active sets `protocol_err`; otherwise no-op.
- Storage index = {ba, open_row[ba], col}. READ/WRITE to inactive bank sets `protocol_err`; command otherwise ignored.
- WRITE: beat 0 data sampled on the command edge, further BL-1 beats on following edges; each beat writes unmasked lanes only.
- READ: beat k drives word for burst column on dq during the cycle beginning CL+k edges after the command edge. `sdram_dqm` ignored for reads.
- Burst column order: sequential, wrapping within the BL-aligned block (col[2:0] low bits wrap, upper col bits fixed).
- A new READ, WRITE or BURST TERMINATE, or PRECHARGE of the bursting bank, stops further beat generation; read beats already queued in the CL pipeline still drive.

## Timing
- Reset (async): `sdram_dq` high-Z immediately, `protocol_err`=0, all banks inactive, mode = BL1/CL2, burst and read pipeline cleared. Storage contents retained across reset.
- Read pipeline is a CL-deep shift of {valid, data}; dq output enable = head valid, registered off the clock edge.
- Single read, CL=2: READ on edge n → data valid on dq from just after edge n+2 to edge n+3; high-Z again after n+3.
- Back-to-back READs on consecutive edges (BL=1) produce contiguous beats with no high-Z gap.
- WRITE on the same edge a read beat is driven sets `protocol_err` (bus contention); write still performed with sampled dq.
- `cke` low for k edges delays all pending beats by k edges.
- `protocol_err` cleared only by reset.

## Test plan
- Reset, LOAD MODE a=0x020 (CL2, BL1), ACTIVE ba=1 row=0x12, WRITE col=0x4 dq=0xDEADBEEF dqm=0, READ col=0x4 → 0xDEADBEEF on dq 2 cycles after READ, high-Z otherwise.
- Write 0x11223344 then WRITE same address dq=0xAABBCCDD dqm=0b0101 → read returns 0xAA22CC44.
- Mode BL=4 CL=3, write 4 beats 0..3 at col 0, READ col=2 → beats 3 edges later: data of col 2,3,0,1.
- READ to bank 2 without ACTIVE → `protocol_err`=1, dq stays high-Z; stays 1 until reset.
- PRECHARGE a[10]=1 after opening banks 0 and 3, then AUTO REFRESH → `protocol_err` stays 0; READ bank 3 → error.
- Assert reset while BL=8 read mid-burst → dq high-Z same cycle; after reset, re-ACTIVE and read returns previously written data.
